// File: rtl/serial_word_assembler.sv
// Purpose: assembles MSB-first serial bits into DATA_W-bit words, counts words per frame, flags partial frames.
// Latency: dataOut/dataValid register on the edge that shifts the last bit (parity bit when SERIAL_PARITY_EN).
// Backpressure: none; the upstream controller paces bits with shEn and the consumer must take each dataValid pulse.
// Optional feature macro: SERIAL_PARITY_EN (trailing even-parity bit per word, adds PARITY state and parErr).
module serial_word_assembler #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              serIn,
    input  logic              shEn,
    input  logic              Done,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    output logic [CNT_W-1:0]  wordCnt,
    output logic              frameErr,
`ifdef SERIAL_PARITY_EN
    output logic              parErr,
`endif
    output logic              busy
);

    // Bit counter must be able to represent DATA_W itself for the completion compare.
    localparam int                BCW     = $clog2(DATA_W + 1);
    localparam logic [BCW-1:0]    LAST    = BCW'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

    state_t              state, stateNxt;
    logic [DATA_W-1:0]   shReg, shRegNxt;
    logic [BCW-1:0]      bitCnt, bitCntNxt;
    logic [DATA_W-1:0]   dataOutNxt;
    logic                dataValidNxt;
    logic [CNT_W-1:0]    wordCntNxt;
    logic                frameErrNxt;
`ifdef SERIAL_PARITY_EN
    logic                parErrNxt;
`endif

    logic [DATA_W-1:0]   shifted;
    logic [BCW-1:0]      cntInc;
    logic [CNT_W-1:0]    wordCntInc;
    // Bits still pending after this edge's shift; nonzero at frame end means a partial word.
    logic [BCW-1:0]      cntAfter;

    // Shared arithmetic: next shift-register image, bit count and saturating word count.
    always_comb begin
        shifted    = {shReg[DATA_W-2:0], serIn};
        cntInc     = bitCnt + BCW'(1);
        wordCntInc = (wordCnt == CNT_MAX) ? wordCnt : wordCnt + CNT_W'(1);
    end

    // Next-state and registered-output logic; on a Done edge the shift is applied first, then the frame end is judged.
    always_comb begin
        stateNxt     = state;
        shRegNxt     = shReg;
        bitCntNxt    = bitCnt;
        dataOutNxt   = dataOut;
        dataValidNxt = 1'b0;
        wordCntNxt   = wordCnt;
        frameErrNxt  = 1'b0;
        cntAfter     = bitCnt;
`ifdef SERIAL_PARITY_EN
        parErrNxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Done alone in IDLE is ignored; only a shift opens a frame.
                if (shEn) begin
                    shRegNxt   = shifted;
                    bitCntNxt  = BCW'(1);
                    wordCntNxt = '0;
                    stateNxt   = COLLECT;
                end
            end
            COLLECT: begin
                if (shEn) begin
                    shRegNxt = shifted;
                    if (cntInc == LAST) begin
`ifdef SERIAL_PARITY_EN
                        // Word held in shReg until its parity bit arrives; still counts as pending.
                        bitCntNxt = '0;
                        cntAfter  = LAST;
                        stateNxt  = PARITY;
`else
                        dataOutNxt   = shifted;
                        dataValidNxt = 1'b1;
                        bitCntNxt    = '0;
                        cntAfter     = '0;
                        wordCntNxt   = wordCntInc;
`endif
                    end else begin
                        bitCntNxt = cntInc;
                        cntAfter  = cntInc;
                    end
                end
                if (Done) begin
                    stateNxt  = IDLE;
                    bitCntNxt = '0;
                    shRegNxt  = '0;
                    if (cntAfter != '0) begin
                        frameErrNxt = 1'b1;
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            PARITY: begin
                if (shEn) begin
                    // Even parity: data plus parity bit must hold an even number of ones.
                    dataOutNxt   = shReg;
                    dataValidNxt = 1'b1;
                    parErrNxt    = ^{shReg, serIn};
                    wordCntNxt   = wordCntInc;
                    stateNxt     = COLLECT;
                end
                if (Done) begin
                    stateNxt  = IDLE;
                    bitCntNxt = '0;
                    shRegNxt  = '0;
                    if (!shEn) begin
                        frameErrNxt = 1'b1;
                    end
                end
            end
`endif
            default: begin
                stateNxt  = IDLE;
                bitCntNxt = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial word without producing pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            shReg     <= '0;
            bitCnt    <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            wordCnt   <= '0;
            frameErr  <= 1'b0;
`ifdef SERIAL_PARITY_EN
            parErr    <= 1'b0;
`endif
        end else begin
            state     <= stateNxt;
            shReg     <= shRegNxt;
            bitCnt    <= bitCntNxt;
            dataOut   <= dataOutNxt;
            dataValid <= dataValidNxt;
            wordCnt   <= wordCntNxt;
            frameErr  <= frameErrNxt;
`ifdef SERIAL_PARITY_EN
            parErr    <= parErrNxt;
`endif
        end
    end

    // A frame is in progress whenever the FSM has left IDLE.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Purpose: directed self-checking bench for serial_word_assembler (default build).
// Latency: inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next one.
// Backpressure: not applicable; pulses are also tallied on falling edges.
module tb_serial_word_assembler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       serIn;
    logic       shEn;
    logic       Done;
    logic [7:0] dataOut;
    logic       dataValid;
    logic [3:0] wordCnt;
    logic       frameErr;
    logic       busy;
`ifdef SERIAL_PARITY_EN
    logic       parErr;
`endif

    int checks   = 0;
    int errors   = 0;
    int vldCnt   = 0;
    int ferrCnt  = 0;

    serial_word_assembler #(.DATA_W(8), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .serIn     (serIn),
        .shEn      (shEn),
        .Done      (Done),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .wordCnt   (wordCnt),
        .frameErr  (frameErr),
`ifdef SERIAL_PARITY_EN
        .parErr    (parErr),
`endif
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Tally every cycle that shows a pulse, sampled away from the active edge.
    always @(negedge CLK) begin
        if (dataValid === 1'b1) vldCnt++;
        if (frameErr === 1'b1) ferrCnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 ns after the sampling edge.
    task automatic step(input logic sh, input logic b, input logic dn);
        shEn  = sh;
        serIn = b;
        Done  = dn;
        @(posedge CLK);
        #1;
        shEn  = 1'b0;
        serIn = 1'b0;
        Done  = 1'b0;
    endtask

    // Full word MSB first, with 'gap' idle cycles between bits; Done optionally on the last bit.
    task automatic sendWord(input logic [7:0] w, input int gap, input logic doneLast);
        for (int i = 7; i >= 0; i--) begin
            if (i != 7) begin
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
            end
            step(1'b1, w[i], (i == 0) ? doneLast : 1'b0);
        end
    endtask

    // First n bits of w, MSB first.
    task automatic sendBits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[7-i], 1'b0);
    endtask

    initial begin
        RST   = 1'b1;
        serIn = 1'b0;
        shEn  = 1'b0;
        Done  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_dataOut",   dataOut,   8'h00);
        chk("rst_dataValid", dataValid, 1'b0);
        chk("rst_wordCnt",   wordCnt,   4'h0);
        chk("rst_frameErr",  frameErr,  1'b0);
        chk("rst_busy",      busy,      1'b0);
        RST = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Single word A5, valid on the 8th bit edge only.
        sendBits(8'hA5, 7);
        chk("a5_noEarlyValid", vldCnt, 0);
        chk("a5_busy", busy, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("a5_valid",   dataValid, 1'b1);
        chk("a5_dataOut", dataOut,   8'hA5);
        chk("a5_wordCnt", wordCnt,   4'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("a5_validOneCycle", dataValid, 1'b0);
        chk("a5_busyAfterDone", busy,      1'b0);
        chk("a5_frameErr",      frameErr,  1'b0);
        chk("a5_wordCntHold",   wordCnt,   4'h1);
        chk("a5_vldCnt",        vldCnt,    1);

        // Done in IDLE is ignored.
        step(1'b0, 1'b0, 1'b1);
        chk("idleDone_frameErr", frameErr, 1'b0);
        chk("idleDone_busy",     busy,     1'b0);

        // Two words with gaps between bits.
        sendWord(8'h3C, 3, 1'b0);
        chk("w3c_dataOut", dataOut, 8'h3C);
        chk("w3c_wordCnt", wordCnt, 4'h1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        sendWord(8'hFF, 3, 1'b0);
        chk("wff_dataOut", dataOut, 8'hFF);
        chk("wff_wordCnt", wordCnt, 4'h2);
        chk("wff_busy",    busy,    1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("wff_busyDrop", busy, 1'b0);
        chk("two_vldCnt",   vldCnt, 3);
        chk("two_ferrCnt",  ferrCnt, 0);

        // Partial frame of 5 bits.
        sendBits(8'hC8, 5);
        step(1'b0, 1'b0, 1'b1);
        chk("part_frameErr", frameErr, 1'b1);
        chk("part_dataOut",  dataOut,  8'hFF);
        chk("part_busy",     busy,     1'b0);
        chk("part_valid",    dataValid, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("part_pulseOne", frameErr, 1'b0);
        chk("part_ferrCnt",  ferrCnt,  1);
        sendWord(8'h5A, 0, 1'b0);
        chk("after_dataOut", dataOut, 8'h5A);
        chk("after_wordCnt", wordCnt, 4'h1);
        step(1'b0, 1'b0, 1'b1);

        // Last bit and Done on the same edge: clean end.
        sendWord(8'hC3, 0, 1'b1);
        chk("same_valid",    dataValid, 1'b1);
        chk("same_frameErr", frameErr,  1'b0);
        chk("same_busy",     busy,      1'b0);
        chk("same_dataOut",  dataOut,   8'hC3);
        step(1'b0, 1'b0, 1'b0);
        chk("same_ferrCnt",  ferrCnt,   1);

        // Asynchronous reset between edges after 4 bits.
        sendBits(8'h81, 4);
        #3;
        RST = 1'b1;
        #1;
        chk("arst_dataOut",   dataOut,   8'h00);
        chk("arst_wordCnt",   wordCnt,   4'h0);
        chk("arst_busy",      busy,      1'b0);
        chk("arst_dataValid", dataValid, 1'b0);
        chk("arst_frameErr",  frameErr,  1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("arst_noPulse", vldCnt, 5);
        sendWord(8'h81, 0, 1'b0);
        chk("post_dataOut", dataOut, 8'h81);
        chk("post_wordCnt", wordCnt, 4'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("post_vldCnt",  vldCnt,  6);
        chk("post_ferrCnt", ferrCnt, 1);

        // Word counter saturation: 16 words in one frame.
        for (int k = 0; k < 15; k++) begin
            logic [7:0] wv;
            wv = 8'(k);
            sendWord(wv, 0, 1'b0);
        end
        chk("sat_wordCnt15", wordCnt, 4'hF);
        sendWord(8'h0F, 0, 1'b0);
        chk("sat_wordCntHold", wordCnt, 4'hF);
        chk("sat_dataOut",     dataOut, 8'h0F);
        step(1'b0, 1'b0, 1'b1);
        chk("sat_busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("sat_vldCnt", vldCnt, 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
